nic3_pwr_seq: RTL and testbench
===============================

Name: nic3_pwr_seq

Overview:
- Power-sequencing controller for one OCP NIC3 slot.
- Drives the slot's aux rail enable, main rail enable and PERST#.
- Uses the existing delay-timer block for every timed step. It drives that block's enable and 16-bit time value and consumes its timeout pulse.
- Sits directly upstream of the delay timer. Receives the slot power request from board-level control logic and reports status and faults back to it.

Parameters:
- T_AUX_PG, 16'd10000: max cycles waiting for aux_pg after aux_en asserts.
- T_AUX2MAIN, 16'd5000: settle delay from aux good to main enable.
- T_MAIN_PG, 16'd10000: max cycles waiting for main_pg after main_en asserts.
- T_PERST, 16'd20000: delay from main good to PERST# release.
- T_PD, 16'd2000: step delay between power-down stages.

Ports:
- clk_in, in, 1: sequencer clock, shared with the delay timer.
- iRst_n, in, 1: asynchronous active-low reset.
- pwr_req, in, 1: slot power request, synchronous to clk_in.
- aux_pg, in, 1: aux rail power good, asynchronous.
- main_pg, in, 1: main rail power good, asynchronous.
- dly_timeout, in, 1: timeout pulse from the delay timer.
- dly_timer_en, out, 1: delay timer enable. Low clears the timer.
- dly_time, out, 16: delay timer terminal count.
- aux_en, out, 1: aux rail enable.
- main_en, out, 1: main rail enable.
- perst_n, out, 1: PCIe reset to the NIC, active low.
- pwr_ok, out, 1: slot fully powered.
- fault, out, 1: sequencing fault latched.
- fault_code, out, 2: 01 = aux PG timeout, 10 = main PG timeout, 11 = PG lost.
- seq_state, out, 4: current state encoding, for debug.

Behaviour:
- Reset values:
  - aux_en, main_en, pwr_ok, fault, dly_timer_en = 0; perst_n = 0.
  - dly_time = 0; fault_code = 00; state = S_OFF.
  - PG synchronisers cleared.
- Reset mid-sequence drops every rail enable asynchronously. There is no orderly power-down on reset.
- aux_pg and main_pg each pass through a 2-flop synchroniser, giving 2 cycles of latency. All PG references below mean the synchronised value.
- All outputs are registered.
- Timer protocol:
  - dly_timer_en = 0 on the first cycle in any timed state, then 1 while the state is held.
  - dly_time is registered and valid from the state's first cycle.
  - dly_timeout is honoured only when dly_timer_en = 1.
  - The timer pulses dly_time+1 cycles after its enable rises, so a timed step lasts dly_time+2 cycles from state entry.
  - Leaving a timed state for another timed state always produces ≥1 cycle of dly_timer_en = 0, which clears the timer.
- States, with codes and timer load:
  - S_OFF (0): all off. pwr_req=1 → S_AUX_WAIT.
  - S_AUX_WAIT (1), dly_time=T_AUX_PG: aux_en=1.
    - aux_pg=1 → S_AUX_DLY.
    - Timeout → S_FAULT with code 01.
  - S_AUX_DLY (2), dly_time=T_AUX2MAIN: on timeout → S_MAIN_WAIT.
  - S_MAIN_WAIT (3), dly_time=T_MAIN_PG: main_en=1.
    - main_pg=1 → S_PERST_DLY.
    - Timeout → S_FAULT with code 10.
  - S_PERST_DLY (4), dly_time=T_PERST: on timeout → S_ON.
  - S_ON (5): perst_n=1, pwr_ok=1. Timer disabled.
  - S_PD_PERST (6), dly_time=T_PD: perst_n=0 and pwr_ok=0 on entry. On timeout → S_PD_MAIN.
  - S_PD_MAIN (7), dly_time=T_PD: main_en=0 on entry. On timeout → S_OFF, where aux_en=0.
  - S_FAULT (8): aux_en, main_en, perst_n, pwr_ok = 0; fault=1. pwr_req=0 → S_OFF, which clears fault and fault_code.
- PG loss:
  - In S_AUX_DLY and later power-up states, aux_pg=0 → S_FAULT with code 11.
  - In S_PERST_DLY or S_ON, main_pg=0 → S_FAULT with code 11.
  - PG checks are not applied in the power-down states.
- pwr_req withdrawal:
  - pwr_req=0 in S_ON → S_PD_PERST.
  - pwr_req=0 in states 1–4 → S_PD_PERST, giving a full orderly down-sequence.
  - pwr_req=1 during S_PD_* is ignored until S_OFF is reached. Re-entry to S_AUX_WAIT takes 1 cycle after that.
- Same-cycle priority: fault detection > dly_timeout > pwr_req. A PG timeout coinciding with PG arrival counts as arrival.
- dly_time of 0 is legal: the step lasts 2 cycles.

Test Plan:
- Normal power-up, params 10/5/10/20/2: assert pwr_req; aux_pg rises 3 cycles after aux_en; main_pg rises 4 cycles after main_en.
  - Required: main_en rises exactly 7 cycles after the synchronised aux_pg is seen.
  - Required: perst_n and pwr_ok rise 22 cycles after the synchronised main_pg.
- Aux PG timeout: aux_pg held 0 → 12 cycles after S_AUX_WAIT entry, state=8, fault=1, fault_code=01, aux_en=0.
  - Then drop pwr_req → state=0, fault=0.
- Orderly power-down from S_ON: drop pwr_req.
  - perst_n=0 next cycle.
  - main_en=0 4 cycles later.
  - aux_en=0 4 cycles after that.
  - dly_timer_en shows a 0 gap between the two T_PD steps.
- PG glitch in S_ON: main_pg low for 3 cycles → fault_code=11, all enables 0 within 3 cycles, pwr_ok=0.
- Reset mid-sequence: assert iRst_n=0 in S_PERST_DLY.
  - Required: all outputs reach reset values with no clock.
  - Required: after release with pwr_req=1, the sequence restarts at S_AUX_WAIT.
- pwr_req withdrawn in S_AUX_DLY with a coincident timeout → the full down-sequence via S_PD_PERST; main_en never asserts.

Source files
------------

// File: rtl/nic3_pwr_seq.sv
// OCP NIC3 slot power sequencer: steps the aux rail, main rail and PERST# through
// an external delay timer, and latches a fault code when a power-good check fails.
`timescale 1ns/1ps
module nic3_pwr_seq #(
    parameter logic [15:0] T_AUX_PG   = 16'd10000,
    parameter logic [15:0] T_AUX2MAIN = 16'd5000,
    parameter logic [15:0] T_MAIN_PG  = 16'd10000,
    parameter logic [15:0] T_PERST    = 16'd20000,
    parameter logic [15:0] T_PD       = 16'd2000
) (
    input  logic        clk_in,
    input  logic        iRst_n,
    input  logic        pwr_req,
    input  logic        aux_pg,
    input  logic        main_pg,
    input  logic        dly_timeout,
    output logic        dly_timer_en,
    output logic [15:0] dly_time,
    output logic        aux_en,
    output logic        main_en,
    output logic        perst_n,
    output logic        pwr_ok,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [3:0]  seq_state
);

    typedef enum logic [3:0] {
        S_OFF       = 4'd0,
        S_AUX_WAIT  = 4'd1,
        S_AUX_DLY   = 4'd2,
        S_MAIN_WAIT = 4'd3,
        S_PERST_DLY = 4'd4,
        S_ON        = 4'd5,
        S_PD_PERST  = 4'd6,
        S_PD_MAIN   = 4'd7,
        S_FAULT     = 4'd8
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_AUX_TMO  = 2'b01;
    localparam logic [1:0] FC_MAIN_TMO = 2'b10;
    localparam logic [1:0] FC_PG_LOST  = 2'b11;

    state_t      state_q, state_d;
    logic        aux_pg_meta_q, aux_pg_meta_d;
    logic        aux_pg_sync_q, aux_pg_sync_d;
    logic        main_pg_meta_q, main_pg_meta_d;
    logic        main_pg_sync_q, main_pg_sync_d;
    logic        dly_timer_en_q, dly_timer_en_d;
    logic [15:0] dly_time_q, dly_time_d;
    logic        aux_en_q, aux_en_d;
    logic        main_en_q, main_en_d;
    logic        perst_n_q, perst_n_d;
    logic        pwr_ok_q, pwr_ok_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        tmo;

    function automatic logic is_timed(input state_t s);
        case (s)
            S_AUX_WAIT, S_AUX_DLY, S_MAIN_WAIT,
            S_PERST_DLY, S_PD_PERST, S_PD_MAIN: is_timed = 1'b1;
            default:                            is_timed = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] step_time(input state_t s);
        case (s)
            S_AUX_WAIT:             step_time = T_AUX_PG;
            S_AUX_DLY:              step_time = T_AUX2MAIN;
            S_MAIN_WAIT:            step_time = T_MAIN_PG;
            S_PERST_DLY:            step_time = T_PERST;
            S_PD_PERST, S_PD_MAIN:  step_time = T_PD;
            default:                step_time = 16'd0;
        endcase
    endfunction

    // A timeout only counts once the timer has actually been enabled in this state.
    assign tmo = dly_timeout & dly_timer_en_q;

    always_comb begin
        aux_pg_meta_d  = aux_pg;
        aux_pg_sync_d  = aux_pg_meta_q;
        main_pg_meta_d = main_pg;
        main_pg_sync_d = main_pg_meta_q;
    end

    // Power-up advances fall back to the orderly down-sequence when the request has gone away,
    // so a withdrawn request never turns on a further rail.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            S_OFF: begin
                if (pwr_req) state_d = S_AUX_WAIT;
            end
            S_AUX_WAIT: begin
                if (aux_pg_sync_q) begin
                    state_d = pwr_req ? S_AUX_DLY : S_PD_PERST;
                end else if (tmo) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_AUX_TMO;
                end else if (!pwr_req) begin
                    state_d = S_PD_PERST;
                end
            end
            S_AUX_DLY: begin
                if (!aux_pg_sync_q) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_PG_LOST;
                end else if (tmo) begin
                    state_d = pwr_req ? S_MAIN_WAIT : S_PD_PERST;
                end else if (!pwr_req) begin
                    state_d = S_PD_PERST;
                end
            end
            S_MAIN_WAIT: begin
                if (!aux_pg_sync_q) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_PG_LOST;
                end else if (main_pg_sync_q) begin
                    state_d = pwr_req ? S_PERST_DLY : S_PD_PERST;
                end else if (tmo) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_MAIN_TMO;
                end else if (!pwr_req) begin
                    state_d = S_PD_PERST;
                end
            end
            S_PERST_DLY: begin
                if (!aux_pg_sync_q || !main_pg_sync_q) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_PG_LOST;
                end else if (tmo) begin
                    state_d = pwr_req ? S_ON : S_PD_PERST;
                end else if (!pwr_req) begin
                    state_d = S_PD_PERST;
                end
            end
            S_ON: begin
                if (!aux_pg_sync_q || !main_pg_sync_q) begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_PG_LOST;
                end else if (!pwr_req) begin
                    state_d = S_PD_PERST;
                end
            end
            S_PD_PERST: begin
                if (tmo) state_d = S_PD_MAIN;
            end
            S_PD_MAIN: begin
                if (tmo) state_d = S_OFF;
            end
            S_FAULT: begin
                if (!pwr_req) state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
        if (state_d == S_OFF) fault_code_d = FC_NONE;
    end

    // Outputs are decoded from the next state so every one of them is a flop.
    always_comb begin
        aux_en_d  = 1'b0;
        main_en_d = 1'b0;
        perst_n_d = 1'b0;
        pwr_ok_d  = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            S_AUX_WAIT, S_AUX_DLY, S_PD_MAIN: begin
                aux_en_d = 1'b1;
            end
            S_MAIN_WAIT, S_PERST_DLY: begin
                aux_en_d  = 1'b1;
                main_en_d = 1'b1;
            end
            S_ON: begin
                aux_en_d  = 1'b1;
                main_en_d = 1'b1;
                perst_n_d = 1'b1;
                pwr_ok_d  = 1'b1;
            end
            S_PD_PERST: begin
                aux_en_d  = 1'b1;
                main_en_d = main_en_q;
            end
            S_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                aux_en_d = 1'b0;
            end
        endcase
        dly_time_d     = step_time(state_d);
        dly_timer_en_d = (state_d == state_q) && is_timed(state_d);
    end

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q        <= S_OFF;
            aux_pg_meta_q  <= 1'b0;
            aux_pg_sync_q  <= 1'b0;
            main_pg_meta_q <= 1'b0;
            main_pg_sync_q <= 1'b0;
            dly_timer_en_q <= 1'b0;
            dly_time_q     <= 16'd0;
            aux_en_q       <= 1'b0;
            main_en_q      <= 1'b0;
            perst_n_q      <= 1'b0;
            pwr_ok_q       <= 1'b0;
            fault_q        <= 1'b0;
            fault_code_q   <= FC_NONE;
        end else begin
            state_q        <= state_d;
            aux_pg_meta_q  <= aux_pg_meta_d;
            aux_pg_sync_q  <= aux_pg_sync_d;
            main_pg_meta_q <= main_pg_meta_d;
            main_pg_sync_q <= main_pg_sync_d;
            dly_timer_en_q <= dly_timer_en_d;
            dly_time_q     <= dly_time_d;
            aux_en_q       <= aux_en_d;
            main_en_q      <= main_en_d;
            perst_n_q      <= perst_n_d;
            pwr_ok_q       <= pwr_ok_d;
            fault_q        <= fault_d;
            fault_code_q   <= fault_code_d;
        end
    end

    assign dly_timer_en = dly_timer_en_q;
    assign dly_time     = dly_time_q;
    assign aux_en       = aux_en_q;
    assign main_en      = main_en_q;
    assign perst_n      = perst_n_q;
    assign pwr_ok       = pwr_ok_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;
    assign seq_state    = state_q;

endmodule

// File: tb/tb_nic3_pwr_seq.sv
// Bench for nic3_pwr_seq: directed power sequences; every state change is scored against
// a queue of expected output vectors and dwell times in the state just left.
`timescale 1ns/1ps
module tb_nic3_pwr_seq;

    logic        clk_in  = 1'b0;
    logic        iRst_n  = 1'b1;
    logic        pwr_req = 1'b0;
    logic        aux_pg  = 1'b0;
    logic        main_pg = 1'b0;
    logic        dly_timeout;
    logic        dly_timer_en;
    logic [15:0] dly_time;
    logic        aux_en, main_en, perst_n, pwr_ok, fault;
    logic [1:0]  fault_code;
    logic [3:0]  seq_state;

    logic        clk_run = 1'b1;
    int          total   = 0;
    int          bad     = 0;
    int          cyc     = 0;
    int          last_cyc = 0;
    logic [3:0]  last_state = 4'd0;
    int          tmr_cnt = 0;

    typedef struct {
        string       tag;
        logic [27:0] outs;
        int          dwell;
    } exp_t;
    exp_t sb[$];

    nic3_pwr_seq #(
        .T_AUX_PG   (16'd10),
        .T_AUX2MAIN (16'd5),
        .T_MAIN_PG  (16'd10),
        .T_PERST    (16'd20),
        .T_PD       (16'd2)
    ) dut (
        .clk_in       (clk_in),
        .iRst_n       (iRst_n),
        .pwr_req      (pwr_req),
        .aux_pg       (aux_pg),
        .main_pg      (main_pg),
        .dly_timeout  (dly_timeout),
        .dly_timer_en (dly_timer_en),
        .dly_time     (dly_time),
        .aux_en       (aux_en),
        .main_en      (main_en),
        .perst_n      (perst_n),
        .pwr_ok       (pwr_ok),
        .fault        (fault),
        .fault_code   (fault_code),
        .seq_state    (seq_state)
    );

    initial begin
        forever begin
            #5;
            if (clk_run) clk_in = ~clk_in;
        end
    end

    // Delay-timer peer: cleared while disabled, pulses once the count reaches dly_time.
    always @(posedge clk_in) begin
        if (!dly_timer_en) tmr_cnt <= 0;
        else               tmr_cnt <= tmr_cnt + 1;
    end
    assign dly_timeout = dly_timer_en && (tmr_cnt == int'(dly_time));

    function automatic logic [27:0] mk(input int st, input bit a, input bit m, input bit p,
                                       input bit ok, input bit f, input int code,
                                       input bit ten, input int dt);
        logic [3:0]  st4;
        logic [1:0]  c2;
        logic [15:0] dt16;
        st4  = st[3:0];
        c2   = code[1:0];
        dt16 = dt[15:0];
        return {st4, a, m, p, ok, f, c2, ten, dt16};
    endfunction

    task automatic pushExpect(input string tag, input int st, input bit a, input bit m,
                              input bit p, input bit ok, input bit f, input int code,
                              input bit ten, input int dt, input int dwell);
        exp_t e;
        e.tag   = tag;
        e.outs  = mk(st, a, m, p, ok, f, code, ten, dt);
        e.dwell = dwell;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic req, input logic apg, input logic mpg);
        pwr_req = req;
        aux_pg  = apg;
        main_pg = mpg;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_state"},      32'(seq_state),    32'd0);
        checkOutput({pfx, "_aux_en"},     32'(aux_en),       32'd0);
        checkOutput({pfx, "_main_en"},    32'(main_en),      32'd0);
        checkOutput({pfx, "_perst_n"},    32'(perst_n),      32'd0);
        checkOutput({pfx, "_pwr_ok"},     32'(pwr_ok),       32'd0);
        checkOutput({pfx, "_fault"},      32'(fault),        32'd0);
        checkOutput({pfx, "_fault_code"}, 32'(fault_code),   32'd0);
        checkOutput({pfx, "_timer_en"},   32'(dly_timer_en), 32'd0);
        checkOutput({pfx, "_dly_time"},   32'(dly_time),     32'd0);
    endtask

    // Monitor: each time the state changes, score the new outputs and the dwell in the old state.
    always @(negedge clk_in) begin
        exp_t        e;
        logic [27:0] act;
        cyc++;
        if (seq_state !== last_state) begin
            act = {seq_state, aux_en, main_en, perst_n, pwr_ok, fault, fault_code, dly_timer_en, dly_time};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_transition actual=%0d required=none", seq_state);
            end else begin
                e = sb.pop_front();
                if (act !== e.outs) begin
                    bad++;
                    $display("[TB] FAIL %s_outs actual=%07h required=%07h", e.tag, act, e.outs);
                end
                if (e.dwell >= 0) begin
                    total++;
                    if (cyc - last_cyc != e.dwell) begin
                        bad++;
                        $display("[TB] FAIL %s_dwell actual=%0d required=%0d", e.tag, cyc - last_cyc, e.dwell);
                    end
                end
            end
            last_state = seq_state;
            last_cyc   = cyc;
        end
    end

    initial begin
        #1 iRst_n = 1'b0;
        tick(2);
        checkResetValues("por");
        iRst_n = 1'b1;
        tick(2);

        $display("[TB] normal power-up");
        pushExpect("pu_aux_wait",  1, 1, 0, 0, 0, 0, 0, 0, 10, -1);
        pushExpect("pu_aux_dly",   2, 1, 0, 0, 0, 0, 0, 0, 5,   6);
        pushExpect("pu_main_wait", 3, 1, 1, 0, 0, 0, 0, 0, 10,  7);
        pushExpect("pu_perst_dly", 4, 1, 1, 0, 0, 0, 0, 0, 20,  7);
        pushExpect("pu_on",        5, 1, 1, 1, 1, 0, 0, 0, 0,  22);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(4);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(14);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(26);

        $display("[TB] orderly power-down, early re-request, aux timeout");
        pushExpect("pd_perst",     6, 1, 1, 0, 0, 0, 0, 0, 2,  2);
        pushExpect("pd_main",      7, 1, 0, 0, 0, 0, 0, 0, 2,  4);
        pushExpect("pd_off",       0, 0, 0, 0, 0, 0, 0, 0, 0,  4);
        pushExpect("rr_aux_wait",  1, 1, 0, 0, 0, 0, 0, 0, 10, 1);
        pushExpect("tmo_fault",    8, 0, 0, 0, 0, 1, 1, 0, 0, 12);
        pushExpect("tmo_off",      0, 0, 0, 0, 0, 0, 0, 0, 0,  2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(17);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);

        $display("[TB] main PG glitch in S_ON");
        pushExpect("gl_aux_wait",  1, 1, 0, 0, 0, 0, 0, 0, 10, 2);
        pushExpect("gl_aux_dly",   2, 1, 0, 0, 0, 0, 0, 0, 5,  2);
        pushExpect("gl_main_wait", 3, 1, 1, 0, 0, 0, 0, 0, 10, 7);
        pushExpect("gl_perst_dly", 4, 1, 1, 0, 0, 0, 0, 0, 20, 1);
        pushExpect("gl_on",        5, 1, 1, 1, 1, 0, 0, 0, 0, 22);
        pushExpect("gl_fault",     8, 0, 0, 0, 0, 1, 3, 0, 0,  5);
        pushExpect("gl_off",       0, 0, 0, 0, 0, 0, 0, 0, 0,  3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(35);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(3);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(2);

        $display("[TB] reset in S_PERST_DLY");
        pushExpect("rs_aux_wait",  1, 1, 0, 0, 0, 0, 0, 0, 10, 2);
        pushExpect("rs_aux_dly",   2, 1, 0, 0, 0, 0, 0, 0, 5,  1);
        pushExpect("rs_main_wait", 3, 1, 1, 0, 0, 0, 0, 0, 10, 7);
        pushExpect("rs_perst_dly", 4, 1, 1, 0, 0, 0, 0, 0, 20, 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(12);
        checkOutput("pre_reset_main_en", 32'(main_en), 32'd1);
        clk_run = 1'b0;
        pushExpect("rs_off", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        #3 iRst_n = 1'b0;
        #2 checkResetValues("midrst");
        #20 clk_run = 1'b1;
        @(negedge clk_in);
        #1 iRst_n = 1'b1;

        $display("[TB] restart, then withdraw request on the S_AUX_DLY timeout");
        pushExpect("wd_aux_wait",  1, 1, 0, 0, 0, 0, 0, 0, 10, -1);
        pushExpect("wd_aux_dly",   2, 1, 0, 0, 0, 0, 0, 0, 5,   2);
        pushExpect("wd_pd_perst",  6, 1, 0, 0, 0, 0, 0, 0, 2,   7);
        pushExpect("wd_pd_main",   7, 1, 0, 0, 0, 0, 0, 0, 2,   4);
        pushExpect("wd_off",       0, 0, 0, 0, 0, 0, 0, 0, 0,   4);
        tick(9);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(16);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
